// File: rtl/debounce_pulse.sv
// Push-button conditioner: 2-flop synchroniser, stability-counter debounce FSM,
// one registered single-cycle T pulse per confirmed press (or release).
module debounce_pulse #(
  parameter int STABLE_CYCLES    = 1000,
  parameter int CNT_W            = 16,
  parameter bit PULSE_ON_RELEASE = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic T,
  output logic LEVEL,
  output logic BUSY
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_t;
  logic             w_t_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_t_nxt     = 1'b0;
    w_level_nxt = r_level;
    case (r_state)
      IDLE_LOW: begin
        if (r_s2) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!r_s2) begin
          w_state_nxt = IDLE_LOW;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = HIGH;
          w_level_nxt = 1'b1;
          w_t_nxt     = (PULSE_ON_RELEASE == 1'b0);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!r_s2) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        // A single high sample sends us back to HIGH; the partial count is dropped.
        if (r_s2) begin
          w_state_nxt = HIGH;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_level_nxt = 1'b0;
          w_t_nxt     = (PULSE_ON_RELEASE == 1'b1);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
      end
    endcase
    w_busy_nxt = (w_state_nxt == WAIT_HIGH) || (w_state_nxt == WAIT_LOW);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_t     <= 1'b0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_s1    <= BTN;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_t     <= w_t_nxt;
      r_level <= w_level_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign T     = r_t;
  assign LEVEL = r_level;
  assign BUSY  = r_busy;

endmodule
